// File: rtl/bus_arbiter.sv
// Two-master arbiter for the system data bus (bridge -> DM / TC0 / TC1).
// Master 0 is the CPU M-stage data port, master 1 a secondary requester
// (DMA / debug loader). Ownership is held in a registered state machine with
// round-robin tie breaking and bounded locked bursts. The selected master's
// fields are steered to the bus in the same cycle its grant is high.
module bus_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m0_req,
  input  logic            m0_lock,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_byteen,
  output logic            m0_gnt,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_lock,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_byteen,
  output logic            m1_gnt,
  output logic [DW-1:0]   m1_rdata,
  output logic [AW-1:0]   bus_addr,
  output logic [DW-1:0]   bus_wdata,
  output logic [DW/8-1:0] bus_byteen,
  input  logic [DW-1:0]   bus_rdata
);

  // Counter is at least one bit wide so MAX_HOLD=1 still elaborates cleanly.
  localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] hold_cnt_r;
  logic          last_r;

  // Ownership state machine; grants are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      hold_cnt_r <= '0;
      last_r     <= 1'b1;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          hold_cnt_r <= '0;
          if (m0_req && m1_req) begin
            // Tie goes to the master that was not served last.
            state_r <= last_r ? OWN0 : OWN1;
            m0_gnt  <= last_r;
            m1_gnt  <= ~last_r;
          end else if (m0_req) begin
            state_r <= OWN0;
            m0_gnt  <= 1'b1;
            m1_gnt  <= 1'b0;
          end else if (m1_req) begin
            state_r <= OWN1;
            m0_gnt  <= 1'b0;
            m1_gnt  <= 1'b1;
          end else begin
            state_r <= IDLE;
            m0_gnt  <= 1'b0;
            m1_gnt  <= 1'b0;
          end
        end
        OWN0: begin
          if (m0_req) begin
            last_r <= 1'b0;
            if (m0_lock && !m1_req) begin
              state_r    <= OWN0;
              hold_cnt_r <= '0;
              m0_gnt     <= 1'b1;
              m1_gnt     <= 1'b0;
            end else if (m0_lock && (hold_cnt_r < HOLD_LAST)) begin
              state_r    <= OWN0;
              hold_cnt_r <= hold_cnt_r + CNT_ONE;
              m0_gnt     <= 1'b1;
              m1_gnt     <= 1'b0;
            end else if (m1_req) begin
              state_r    <= OWN1;
              hold_cnt_r <= '0;
              m0_gnt     <= 1'b0;
              m1_gnt     <= 1'b1;
            end else begin
              state_r    <= IDLE;
              hold_cnt_r <= '0;
              m0_gnt     <= 1'b0;
              m1_gnt     <= 1'b0;
            end
          end else begin
            // Owner withdrew: no transfer, so last served is unchanged.
            hold_cnt_r <= '0;
            state_r    <= m1_req ? OWN1 : IDLE;
            m0_gnt     <= 1'b0;
            m1_gnt     <= m1_req;
          end
        end
        OWN1: begin
          if (m1_req) begin
            last_r <= 1'b1;
            if (m1_lock && !m0_req) begin
              state_r    <= OWN1;
              hold_cnt_r <= '0;
              m0_gnt     <= 1'b0;
              m1_gnt     <= 1'b1;
            end else if (m1_lock && (hold_cnt_r < HOLD_LAST)) begin
              state_r    <= OWN1;
              hold_cnt_r <= hold_cnt_r + CNT_ONE;
              m0_gnt     <= 1'b0;
              m1_gnt     <= 1'b1;
            end else if (m0_req) begin
              state_r    <= OWN0;
              hold_cnt_r <= '0;
              m0_gnt     <= 1'b1;
              m1_gnt     <= 1'b0;
            end else begin
              state_r    <= IDLE;
              hold_cnt_r <= '0;
              m0_gnt     <= 1'b0;
              m1_gnt     <= 1'b0;
            end
          end else begin
            hold_cnt_r <= '0;
            state_r    <= m0_req ? OWN0 : IDLE;
            m0_gnt     <= m0_req;
            m1_gnt     <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          hold_cnt_r <= '0;
          m0_gnt     <= 1'b0;
          m1_gnt     <= 1'b0;
        end
      endcase
    end
  end

  // Steer the owner's fields to the bus; byte enables also need a live request.
  always_comb begin
    bus_addr   = '0;
    bus_wdata  = '0;
    bus_byteen = '0;
    if (m0_gnt) begin
      bus_addr   = m0_addr;
      bus_wdata  = m0_wdata;
      bus_byteen = m0_byteen & {(DW/8){m0_req}};
    end else if (m1_gnt) begin
      bus_addr   = m1_addr;
      bus_wdata  = m1_wdata;
      bus_byteen = m1_byteen & {(DW/8){m1_req}};
    end else begin
      bus_addr   = '0;
      bus_wdata  = '0;
      bus_byteen = '0;
    end
  end

  // Return read data only to the current owner.
  always_comb begin
    m0_rdata = '0;
    m1_rdata = '0;
    if (m0_gnt) begin
      m0_rdata = bus_rdata;
    end else if (m1_gnt) begin
      m1_rdata = bus_rdata;
    end else begin
      m0_rdata = '0;
      m1_rdata = '0;
    end
  end

endmodule
